// File: rtl/adc_record_reader_if.sv
// adc_record_reader_if: capture-RAM read port plus the sample stream handshake.
// master = reader side, slave = RAM/stream-sink side.
interface adc_record_reader_if;
    logic [14:0] oRAddr;
    logic        oRDEN;
    logic [63:0] iRAMData0;
    logic [31:0] iRAMData1;
    logic [15:0] oSample;
    logic [2:0]  oChan;
    logic        oValid;
    logic        iReady;
    logic        oLast;
    modport master (
        output oRAddr, oRDEN, oSample, oChan, oValid, oLast,
        input  iRAMData0, iRAMData1, iReady
    );
    modport slave (
        input  oRAddr, oRDEN, oSample, oChan, oValid, oLast,
        output iRAMData0, iRAMData1, iReady
    );
endinterface

// File: rtl/adc_record_reader.sv
// adc_record_reader: reads 96-bit capture words and streams eight 12-bit channels per word.
// Define READER_SIGN_EXT_EN to sign-extend samples instead of zero-extending them.
module adc_record_reader #(
    parameter int RAM_LATENCY = 2
) (
    input  logic                       adc_clkinp,
    input  logic                       iRstN,
    input  logic [7:0]                 iRcvInterrupt,
    input  logic [15:0]                iRecLength,
    input  logic                       iAbort,
    adc_record_reader_if.master        bus,
    output logic                       oBusy,
    output logic                       oDone
);
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, SERIAL, DONE} state_t;
    state_t      state_q, state_d;
    logic [14:0] len_q, len_d, w_q, w_d, raddr_q, raddr_d;
    logic [2:0]  c_q, c_d, cnt_q, cnt_d, chan_q, chan_d;
    logic [95:0] hold_q, hold_d;
    logic [15:0] sample_q, sample_d;
    logic [11:0] ch;
    logic        irq_low_q, irq_low_d, rden_q, rden_d, valid_q, valid_d;
    logic        last_q, last_d, busy_q, busy_d, done_q, done_d, start;
    logic        unused_irq;
    assign unused_irq = ^iRcvInterrupt[7:1];
    // irq_low_q only arms after a low level is seen, so a level high out of reset never starts
    assign start = iRcvInterrupt[0] & irq_low_q;
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        w_d       = w_q;
        c_d       = c_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        irq_low_d = ~iRcvInterrupt[0];
        if (iAbort)
            state_d = IDLE;
        else
            case (state_q)
                IDLE: if (start) begin
                    len_d   = iRecLength > 16'd16384 ? 15'd16384 : iRecLength[14:0];
                    w_d     = '0;
                    c_d     = '0;
                    state_d = iRecLength == 16'd0 ? DONE : FETCH;
                end
                FETCH: begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
                WAIT: if (cnt_q == 3'(RAM_LATENCY - 1)) begin
                    hold_d  = {iRAMData1_w(), bus.iRAMData0};
                    c_d     = '0;
                    state_d = SERIAL;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
                SERIAL: if (bus.iReady) begin
                    c_d = c_q + 3'd1;
                    if (c_q == 3'd7) begin
                        w_d     = w_q + 15'd1;
                        state_d = w_q + 15'd1 < len_q ? FETCH : DONE;
                    end
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        // channel n sits at bits [12n+11:12n] of {D1,D0}
        ch       = hold_d[7'(c_d) * 7'd12 +: 12];
        valid_d  = state_d == SERIAL;
        chan_d   = valid_d ? c_d : 3'd0;
`ifdef READER_SIGN_EXT_EN
        sample_d = valid_d ? {{4{ch[11]}}, ch} : 16'd0;
`else
        sample_d = valid_d ? {4'd0, ch} : 16'd0;
`endif
        last_d   = valid_d && c_d == 3'd7 && w_d == len_d - 15'd1;
        rden_d   = state_d == FETCH;
        raddr_d  = rden_d ? w_d : raddr_q;
        busy_d   = state_d != IDLE;
        done_d   = state_q == DONE && !iAbort;
    end
    function automatic logic [31:0] iRAMData1_w();
        return bus.iRAMData1;
    endfunction
    always_ff @(posedge adc_clkinp or negedge iRstN) begin
        if (!iRstN) begin
            state_q   <= IDLE;
            len_q     <= '0;
            w_q       <= '0;
            c_q       <= '0;
            cnt_q     <= '0;
            hold_q    <= '0;
            irq_low_q <= 1'b0;
            raddr_q   <= '0;
            rden_q    <= 1'b0;
            sample_q  <= '0;
            chan_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            w_q       <= w_d;
            c_q       <= c_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            irq_low_q <= irq_low_d;
            raddr_q   <= raddr_d;
            rden_q    <= rden_d;
            sample_q  <= sample_d;
            chan_q    <= chan_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end
    assign bus.oRAddr  = raddr_q;
    assign bus.oRDEN   = rden_q;
    assign bus.oSample = sample_q;
    assign bus.oChan   = chan_q;
    assign bus.oValid  = valid_q;
    assign bus.oLast   = last_q;
    assign oBusy       = busy_q;
    assign oDone       = done_q;
endmodule

// File: tb/tb_adc_record_reader.sv
// tb_adc_record_reader: directed scenarios against a latency-accurate capture RAM model.
module tb_adc_record_reader;
    localparam int RL = 2;
    logic        clk = 1'b0, rst_n = 1'b0, abort = 1'b0, rdy = 1'b1, toggle = 1'b0;
    logic [7:0]  irq = '0;
    logic [15:0] rec_len = '0;
    logic        busy, done;
    logic        ovr = 1'b0;
    logic [63:0] ovr0 = '0;
    logic [31:0] ovr1 = '0;
    int          nvec = 0, nerr = 0;

    adc_record_reader_if bus();
    adc_record_reader #(.RAM_LATENCY(RL)) dut (
        .adc_clkinp(clk), .iRstN(rst_n), .iRcvInterrupt(irq), .iRecLength(rec_len),
        .iAbort(abort), .bus(bus), .oBusy(busy), .oDone(done)
    );
    always #5 clk = ~clk;

    function automatic logic [95:0] word(input logic [14:0] a);
        logic [63:0] d0;
        logic [31:0] d1;
        d0 = 64'h0FED_CBA9_8765_4321 + 64'(a) * 64'h0001_0203_0405_0607;
        d1 = 32'h1234_5678 + 32'(a) * 32'h0102_0304;
        return {d1, d0};
    endfunction

    function automatic logic [15:0] ext(input logic [11:0] v);
`ifdef READER_SIGN_EXT_EN
        return {{4{v[11]}}, v};
`else
        return {4'h0, v};
`endif
    endfunction

    function automatic logic [15:0] exp_s(input logic [14:0] a, input logic [2:0] c);
        logic [63:0] d0;
        logic [31:0] d1;
        logic [11:0] v;
        {d1, d0} = word(a);
        case (c)
            3'd0: v = d0[11:0];
            3'd1: v = d0[23:12];
            3'd2: v = d0[35:24];
            3'd3: v = d0[47:36];
            3'd4: v = d0[59:48];
            3'd5: v = {d1[7:0], d0[63:60]};
            3'd6: v = d1[19:8];
            default: v = d1[31:20];
        endcase
        return ext(v);
    endfunction

    logic [95:0] pipe [RL];
    always @(posedge clk) begin
        pipe[0] <= bus.oRDEN ? (ovr ? {ovr1, ovr0} : word(bus.oRAddr)) : {3{32'hDEAD_BEEF}};
        for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.iRAMData0 = pipe[RL-1][63:0];
    assign bus.iRAMData1 = pipe[RL-1][95:64];
    assign bus.iReady    = rdy;

    always @(posedge clk) begin
        #2;
        rdy = toggle ? ~rdy : 1'b1;
    end

    logic [15:0] mon_s[$];
    logic [2:0]  mon_c[$];
    logic        mon_l[$];
    logic [14:0] mon_a[$];
    int          mon_done = 0, mon_stab = 0, mon_valid = 0;
    logic        pv_hold = 1'b0;
    logic [15:0] ps = '0;
    logic [2:0]  pc = '0;
    always @(negedge clk) begin
        if (bus.oValid && bus.iReady) begin
            mon_s.push_back(bus.oSample);
            mon_c.push_back(bus.oChan);
            mon_l.push_back(bus.oLast);
        end
        if (bus.oRDEN) mon_a.push_back(bus.oRAddr);
        if (done) mon_done <= mon_done + 1;
        if (bus.oValid) mon_valid <= mon_valid + 1;
        if (pv_hold && (!bus.oValid || bus.oSample !== ps || bus.oChan !== pc)) mon_stab <= mon_stab + 1;
        pv_hold <= bus.oValid && !bus.iReady;
        ps      <= bus.oSample;
        pc      <= bus.oChan;
    end

    task automatic pulse_start(input logic [15:0] len);
        @(posedge clk); #2;
        rec_len = len;
        irq[0]  = 1'b0;
        @(posedge clk); #2;
        irq[0]  = 1'b1;
    endtask

    task automatic wait_done(input int budget, output logic ok);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(posedge clk); #2;
            n++;
        end
        ok = done;
    endtask

    task automatic test_reset;
        #12;
        nvec++; if (bus.oRAddr !== 15'd0) begin nerr++; $display("FAIL reset_raddr got %0h want 0", bus.oRAddr); end
        nvec++; if ({bus.oRDEN, bus.oValid, bus.oLast, busy, done} !== 5'd0) begin nerr++; $display("FAIL reset_ctrl got %b want 00000", {bus.oRDEN, bus.oValid, bus.oLast, busy, done}); end
        nvec++; if ({bus.oSample, bus.oChan} !== 19'd0) begin nerr++; $display("FAIL reset_data got %h want 0", {bus.oSample, bus.oChan}); end
        @(posedge clk); #2;
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        logic [11:0] hv [8] = '{12'h321, 12'h654, 12'h987, 12'hCBA, 12'hFED, 12'h780, 12'h456, 12'h123};
        int sb, ab, db, n;
        logic ok;
        sb = mon_s.size(); ab = mon_a.size(); db = mon_done;
        pulse_start(16'd1);
        n = 0;
        while (!bus.oValid && n < 20) begin @(posedge clk); #2; n++; end
        nvec++; if (n !== RL + 2) begin nerr++; $display("FAIL single_first_valid got %0d cycles want %0d", n, RL + 2); end
        wait_done(40, ok);
        nvec++; if (!ok) begin nerr++; $display("FAIL single_done got timeout want pulse"); end
        nvec++; if (mon_s.size() - sb !== 8) begin nerr++; $display("FAIL single_count got %0d want 8", mon_s.size() - sb); end
        for (int i = 0; i < 8 && sb + i < mon_s.size(); i++) begin
            nvec++; if (mon_s[sb+i] !== ext(hv[i])) begin nerr++; $display("FAIL single_ch%0d got %h want %h", i, mon_s[sb+i], ext(hv[i])); end
            nvec++; if (mon_c[sb+i] !== 3'(i) || mon_l[sb+i] !== (i == 7)) begin nerr++; $display("FAIL single_tag%0d got chan %0d last %b want chan %0d last %b", i, mon_c[sb+i], mon_l[sb+i], i, i == 7); end
        end
        nvec++; if (mon_a.size() - ab !== 1 || mon_a[ab] !== 15'd0) begin nerr++; $display("FAIL single_addr got %0d reads want 1 read at 0", mon_a.size() - ab); end
        @(posedge clk); #2;
        nvec++; if (done !== 1'b0 || mon_done - db !== 1) begin nerr++; $display("FAIL single_done_width got done %b pulses %0d want 0 and 1", done, mon_done - db); end
    endtask

    task automatic test_toggle;
        int sb, ab, tb0;
        logic ok;
        sb = mon_s.size(); ab = mon_a.size(); tb0 = mon_stab;
        toggle = 1'b1;
        pulse_start(16'd3);
        wait_done(200, ok);
        toggle = 1'b0;
        nvec++; if (!ok) begin nerr++; $display("FAIL toggle_done got timeout want pulse"); end
        nvec++; if (mon_s.size() - sb !== 24) begin nerr++; $display("FAIL toggle_count got %0d want 24", mon_s.size() - sb); end
        for (int i = 0; i < 24 && sb + i < mon_s.size(); i++) begin
            nvec++; if (mon_s[sb+i] !== exp_s(15'(i / 8), 3'(i % 8)) || mon_c[sb+i] !== 3'(i % 8) || mon_l[sb+i] !== (i == 23)) begin
                nerr++; $display("FAIL toggle_s%0d got %h/%0d/%b want %h/%0d/%b", i, mon_s[sb+i], mon_c[sb+i], mon_l[sb+i], exp_s(15'(i / 8), 3'(i % 8)), i % 8, i == 23);
            end
        end
        nvec++; if (mon_stab !== tb0) begin nerr++; $display("FAIL toggle_stable got %0d unstable cycles want 0", mon_stab - tb0); end
        nvec++; if (mon_a.size() - ab !== 3) begin nerr++; $display("FAIL toggle_reads got %0d want 3", mon_a.size() - ab); end
        for (int i = 0; i < 3 && ab + i < mon_a.size(); i++) begin
            nvec++; if (mon_a[ab+i] !== 15'(i)) begin nerr++; $display("FAIL toggle_addr%0d got %0d want %0d", i, mon_a[ab+i], i); end
        end
    endtask

    task automatic test_len_limits;
        int vb, ab, n;
        vb = mon_valid; ab = mon_a.size();
        pulse_start(16'd0);
        n = 0;
        while (!done && n < 10) begin @(posedge clk); #2; n++; end
        nvec++; if (n !== 2) begin nerr++; $display("FAIL len0_done got %0d cycles want 2", n); end
        nvec++; if (mon_valid !== vb || mon_a.size() !== ab) begin nerr++; $display("FAIL len0_idle got %0d valid %0d reads want 0 0", mon_valid - vb, mon_a.size() - ab); end
        pulse_start(16'd20000);
        @(posedge clk); #2;
        nvec++; if (dut.len_q !== 15'd16384) begin nerr++; $display("FAIL len_clamp got %0d want 16384", dut.len_q); end
        abort = 1'b1;
        @(posedge clk); #2;
        abort = 1'b0;
    endtask

    task automatic test_abort;
        int db, ab, sb, n;
        logic ok;
        pulse_start(16'd3);
        n = 0;
        while (!(bus.oValid && bus.oChan == 3'd4) && n < 30) begin @(posedge clk); #2; n++; end
        nvec++; if (n >= 30) begin nerr++; $display("FAIL abort_reach got timeout want 5th sample"); end
        db = mon_done;
        abort = 1'b1;
        @(posedge clk); #2;
        abort = 1'b0;
        nvec++; if ({bus.oValid, bus.oRDEN, busy} !== 3'b000) begin nerr++; $display("FAIL abort_outputs got %b want 000", {bus.oValid, bus.oRDEN, busy}); end
        repeat (30) @(posedge clk);
        #2;
        nvec++; if (mon_done !== db || busy !== 1'b0) begin nerr++; $display("FAIL abort_no_done got %0d pulses busy %b want 0 0", mon_done - db, busy); end
        ab = mon_a.size(); sb = mon_s.size();
        pulse_start(16'd1);
        wait_done(50, ok);
        nvec++; if (!ok || mon_a.size() <= ab || mon_a[ab] !== 15'd0) begin nerr++; $display("FAIL abort_restart got done %b reads %0d want restart at 0", ok, mon_a.size() - ab); end
        nvec++; if (mon_s.size() - sb !== 8 || mon_s[sb] !== exp_s(15'd0, 3'd0)) begin nerr++; $display("FAIL abort_restart_data got %0d samples want 8 from word 0", mon_s.size() - sb); end
    endtask

    task automatic test_sign;
        int sb;
        logic ok;
        logic [15:0] want;
`ifdef READER_SIGN_EXT_EN
        want = 16'hF800;
`else
        want = 16'h0800;
`endif
        sb = mon_s.size();
        ovr = 1'b1; ovr0 = 64'h0000_0000_0000_0800; ovr1 = 32'h0;
        pulse_start(16'd1);
        wait_done(40, ok);
        ovr = 1'b0;
        nvec++; if (!ok || mon_s.size() - sb !== 8) begin nerr++; $display("FAIL sign_run got done %b samples %0d want 1 8", ok, mon_s.size() - sb); end
        else begin
            nvec++; if (mon_s[sb] !== want) begin nerr++; $display("FAIL sign_ext got %h want %h", mon_s[sb], want); end
            nvec++; if (mon_s[sb+1] !== 16'h0) begin nerr++; $display("FAIL sign_zero got %h want 0000", mon_s[sb+1]); end
        end
    endtask

    task automatic test_busy_ignore;
        logic ok, seen;
        pulse_start(16'd1);
        repeat (3) @(posedge clk);
        #2; irq[0] = 1'b0;
        @(posedge clk); #2;
        irq[0] = 1'b1;
        wait_done(40, ok);
        nvec++; if (!ok) begin nerr++; $display("FAIL ignore_done got timeout want pulse"); end
        seen = 1'b0;
        repeat (30) begin @(posedge clk); #2; seen |= busy; end
        nvec++; if (seen !== 1'b0) begin nerr++; $display("FAIL ignore_queued got busy %b want 0", seen); end
    endtask

    task automatic test_reset_mid;
        int n;
        logic ok, seen;
        pulse_start(16'd2);
        n = 0;
        while (!(bus.oValid && bus.oRAddr == 15'd1) && n < 40) begin @(posedge clk); #2; n++; end
        nvec++; if (n >= 40) begin nerr++; $display("FAIL rstmid_reach got timeout want word 1 serial"); end
        #1; rst_n = 1'b0;
        #1;
        nvec++; if ({bus.oRAddr, bus.oSample, bus.oChan} !== 34'd0) begin nerr++; $display("FAIL rstmid_data got %h want 0", {bus.oRAddr, bus.oSample, bus.oChan}); end
        nvec++; if ({bus.oRDEN, bus.oValid, bus.oLast, busy, done} !== 5'd0) begin nerr++; $display("FAIL rstmid_ctrl got %b want 00000", {bus.oRDEN, bus.oValid, bus.oLast, busy, done}); end
        repeat (2) @(posedge clk);
        #2; rst_n = 1'b1;
        seen = 1'b0;
        repeat (30) begin @(posedge clk); #2; seen |= busy | bus.oValid; end
        nvec++; if (seen !== 1'b0) begin nerr++; $display("FAIL rstmid_level got busy %b want 0", seen); end
        pulse_start(16'd1);
        @(posedge clk); #2;
        nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL rstmid_restart got busy %b want 1", busy); end
        wait_done(40, ok);
        nvec++; if (!ok) begin nerr++; $display("FAIL rstmid_done got timeout want pulse"); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_toggle;
        test_len_limits;
        test_abort;
        test_sign;
        test_busy_ignore;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
